// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared FSM state encoding and AXI response codes
// Contents:
//   state_t      : command/transaction FSM states of axil_cfg_master
//   RESP_OKAY    : AXI BRESP/RRESP value 2'b00
//   RESP_SLVERR  : AXI BRESP/RRESP value 2'b10
//   RESP_DECERR  : AXI BRESP/RRESP value 2'b11
package axil_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cfg_master.sv
// rtl/axil_cfg_master.sv - single-outstanding AXI-Lite master driven by a command/response port pair
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_*                    : command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                    : response out (valid/ready, write, rdata, resp)
//   m_aw*, m_w*, m_b*        : AXI-Lite write address / data / response channels
//   m_ar*, m_r*              : AXI-Lite read address / data channels
//   wr_cnt, rd_cnt, err_cnt  : completed writes, completed reads, non-OKAY responses
module axil_cfg_master
   import axil_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_write,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [31:0]         wr_cnt,
   output logic [31:0]         rd_cnt,
   output logic [31:0]         err_cnt
);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;

   // Captured command fields feed the channels directly, so they stay
   // stable for as long as any valid that depends on them is high.
   assign m_awaddr  = addr_q;
   assign m_araddr  = addr_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign cmd_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         m_arvalid <= 1'b0;
         m_bready  <= 1'b0;
         m_rready  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= RESP_OKAY;
         wr_cnt    <= 32'd0;
         rd_cnt    <= 32'd0;
         err_cnt   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     state     <= WR_REQ;
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                  end else begin
                     state     <= RD_REQ;
                     m_arvalid <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               // AW and W retire independently; a channel already retired
               // counts as done so either order (or both at once) advances.
               if (m_awready) m_awvalid <= 1'b0;
               if (m_wready)  m_wvalid  <= 1'b0;
               if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                  state    <= WR_RESP;
                  m_bready <= 1'b1;
               end
            end
            WR_RESP: begin
               if (m_bvalid) begin
                  state     <= RSP;
                  m_bready  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_resp  <= m_bresp;
                  wr_cnt    <= wr_cnt + 32'd1;
                  if (m_bresp != RESP_OKAY) err_cnt <= err_cnt + 32'd1;
               end
            end
            RD_REQ: begin
               if (m_arready) begin
                  state     <= RD_RESP;
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
               end
            end
            RD_RESP: begin
               if (m_rvalid) begin
                  state     <= RSP;
                  m_rready  <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= 1'b0;
                  rsp_rdata <= m_rdata;
                  rsp_resp  <= m_rresp;
                  rd_cnt    <= rd_cnt + 32'd1;
                  if (m_rresp != RESP_OKAY) err_cnt <= err_cnt + 32'd1;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb/tb_axil_cfg_master.sv - directed self-checking bench for axil_cfg_master
module tb_axil_cfg_master;
   import axil_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready;
   logic [1:0]  m_bresp, m_rresp;
   logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
   logic [31:0] wr_cnt, rd_cnt, err_cnt;

   always #5 clk = ~clk;

   axil_cfg_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // slave behaviour knobs, written only by the stimulus block
   int          aw_hold = 1;
   int          w_hold  = 1;
   logic        b_stall = 1'b0;
   logic [1:0]  b_resp_cfg = 2'b00;
   logic [1:0]  r_resp_cfg = 2'b00;
   logic [31:0] r_data_cfg = 32'h0;

   // slave/monitor state, written only by the slave process
   int          aw_cnt = 0, w_cnt = 0;
   int          aw_hs = 0, w_hs = 0, ar_hs = 0;
   int          aw_cycles = 0, w_cycles = 0;
   int          viol = 0;
   logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   logic [31:0] aw_addr_p = 0, w_data_p = 0, ar_addr_p = 0;
   logic [3:0]  w_strb_p = 0;
   logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
   logic [3:0]  last_wstrb = 0;

   // AXI-Lite slave: holds each address/data ready off until the valid has
   // been seen for the configured number of cycles; B/R answer as soon as
   // the master is ready. Also flags any valid that drops or changes payload
   // before its handshake.
   always @(negedge clk) begin
      if (rst) begin
         m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
         m_bvalid = 1'b0; m_bresp = 2'b00;
         m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
         aw_cnt = 0; w_cnt = 0;
         aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
      end else begin
         if (aw_pend && (!m_awvalid || m_awaddr !== aw_addr_p)) viol++;
         if (w_pend && (!m_wvalid || m_wdata !== w_data_p || m_wstrb !== w_strb_p)) viol++;
         if (ar_pend && (!m_arvalid || m_araddr !== ar_addr_p)) viol++;

         if (m_awvalid) begin aw_cnt++; aw_cycles++; end else aw_cnt = 0;
         m_awready = m_awvalid && (aw_cnt >= aw_hold);
         if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; end
         aw_pend = m_awvalid && !m_awready; aw_addr_p = m_awaddr;

         if (m_wvalid) begin w_cnt++; w_cycles++; end else w_cnt = 0;
         m_wready = m_wvalid && (w_cnt >= w_hold);
         if (m_wvalid && m_wready) begin w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
         w_pend = m_wvalid && !m_wready; w_data_p = m_wdata; w_strb_p = m_wstrb;

         m_arready = m_arvalid;
         if (m_arvalid) begin ar_hs++; last_araddr = m_araddr; end
         ar_pend = 1'b0; ar_addr_p = m_araddr;

         m_bvalid = m_bready && !b_stall;
         m_bresp  = b_resp_cfg;
         m_rvalid = m_rready;
         m_rdata  = r_data_cfg;
         m_rresp  = r_resp_cfg;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one command at the current negedge and waits (bounded) for
   // rsp_valid; lat counts negedges from presentation to the first rsp_valid.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic busy_seen);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      busy_seen = cmd_ready;
      while (!rsp_valid && lat < 60) begin
         @(negedge clk);
         lat++;
         busy_seen = busy_seen | cmd_ready;
      end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_after_take", rsp_valid, 1'b0);
      check("cmd_ready_after_take", cmd_ready, 1'b1);
   endtask

   int   lat, aw0, w0, ar0, awc0, wc0;
   logic busy;
   logic stable, any_rsp, any_ready;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0;
      cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
      check("rst_counters", {wr_cnt, rd_cnt}, 64'd0);
      check("rst_err_cnt", err_cnt, 32'd0);

      // zero-wait write
      aw0 = aw_hs; w0 = w_hs;
      issue(1'b1, 32'h0000_0504, 32'h10, 4'hF, lat, busy);
      check("wr1_latency", lat, 3);
      check("wr1_busy", busy, 1'b0);
      check("wr1_aw_count", aw_hs - aw0, 1);
      check("wr1_w_count", w_hs - w0, 1);
      check("wr1_awaddr", last_awaddr, 32'h0000_0504);
      check("wr1_wdata", last_wdata, 32'h10);
      check("wr1_wstrb", last_wstrb, 4'hF);
      check("wr1_rsp_write", rsp_write, 1'b1);
      check("wr1_rsp_resp", rsp_resp, RESP_OKAY);
      check("wr1_rsp_rdata", rsp_rdata, 32'h0);
      check("wr1_wr_cnt", wr_cnt, 32'd1);
      take_rsp();

      // zero-wait read
      ar0 = ar_hs;
      r_data_cfg = 32'h1234_5678;
      issue(1'b0, 32'h0000_0508, 32'hFFFF_FFFF, 4'h0, lat, busy);
      check("rd1_latency", lat, 3);
      check("rd1_ar_count", ar_hs - ar0, 1);
      check("rd1_araddr", last_araddr, 32'h0000_0508);
      check("rd1_rsp_write", rsp_write, 1'b0);
      check("rd1_rsp_rdata", rsp_rdata, 32'h1234_5678);
      check("rd1_rsp_resp", rsp_resp, RESP_OKAY);
      check("rd1_rd_cnt", rd_cnt, 32'd1);
      check("rd1_wr_cnt", wr_cnt, 32'd1);
      take_rsp();

      // write: awready after 5 cycles, wready immediate
      aw_hold = 5; w_hold = 1;
      aw0 = aw_hs; w0 = w_hs; awc0 = aw_cycles; wc0 = w_cycles;
      issue(1'b1, 32'h0000_0700, 32'hCAFE_0001, 4'h5, lat, busy);
      check("wr2_rsp_valid", rsp_valid, 1'b1);
      check("wr2_latency", lat, 7);
      check("wr2_awvalid_cycles", aw_cycles - awc0, 5);
      check("wr2_wvalid_cycles", w_cycles - wc0, 1);
      check("wr2_aw_count", aw_hs - aw0, 1);
      check("wr2_w_count", w_hs - w0, 1);
      check("wr2_wstrb", last_wstrb, 4'h5);
      check("wr2_wr_cnt", wr_cnt, 32'd2);
      take_rsp();

      // write: awready after 2 cycles, wready after 4
      aw_hold = 2; w_hold = 4;
      awc0 = aw_cycles; wc0 = w_cycles;
      issue(1'b1, 32'h0000_0704, 32'h0BAD_F00D, 4'hC, lat, busy);
      check("wr3_latency", lat, 6);
      check("wr3_awvalid_cycles", aw_cycles - awc0, 2);
      check("wr3_wvalid_cycles", w_cycles - wc0, 4);
      check("wr3_wdata", last_wdata, 32'h0BAD_F00D);
      check("wr3_wr_cnt", wr_cnt, 32'd3);
      take_rsp();
      aw_hold = 1; w_hold = 1;

      // read with SLVERR, response held off 4 cycles
      r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = RESP_SLVERR;
      issue(1'b0, 32'h0000_0800, 32'h0, 4'h0, lat, busy);
      check("rd2_latency", lat, 3);
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_write !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF ||
             rsp_resp !== RESP_SLVERR) stable = 1'b0;
         busy = busy | cmd_ready;
      end
      check("rd2_rsp_stable", stable, 1'b1);
      check("rd2_cmd_ready_low", busy, 1'b0);
      check("rd2_rsp_resp", rsp_resp, RESP_SLVERR);
      check("rd2_err_cnt", err_cnt, 32'd1);
      check("rd2_rd_cnt", rd_cnt, 32'd2);
      take_rsp();
      r_resp_cfg = RESP_OKAY;

      // reset while waiting for B
      b_stall = 1'b1;
      cmd_write = 1'b1; cmd_addr = 32'h0000_0900; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 0;
      while (!m_bready && lat < 20) begin @(negedge clk); lat++; end
      check("rst_mid_in_wr_resp", m_bready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; b_stall = 1'b0;
      check("rst_mid_cmd_ready", cmd_ready, 1'b1);
      check("rst_mid_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
      check("rst_mid_counters", {wr_cnt, rd_cnt}, 64'd0);
      check("rst_mid_err_cnt", err_cnt, 32'd0);
      any_rsp = rsp_valid; any_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         any_rsp = any_rsp | rsp_valid;
         any_ready = any_ready | m_bready | m_awvalid | m_wvalid;
      end
      check("rst_mid_no_rsp", any_rsp, 1'b0);
      check("rst_mid_quiet", any_ready, 1'b0);

      // first write after reset, DECERR
      b_resp_cfg = RESP_DECERR;
      issue(1'b1, 32'h0000_0600, 32'hA5A5_A5A5, 4'h3, lat, busy);
      check("wr4_latency", lat, 3);
      check("wr4_rsp_resp", rsp_resp, RESP_DECERR);
      check("wr4_wr_cnt", wr_cnt, 32'd1);
      check("wr4_err_cnt", err_cnt, 32'd1);
      check("wr4_awaddr", last_awaddr, 32'h0000_0600);
      take_rsp();
      b_resp_cfg = RESP_OKAY;

      check("protocol_violations", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axil_cfg_master.md
AXIL_CFG_MASTER -- requirements
Module: axil_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the AXI-Lite data width; only the value 32 is supported.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, sync active-high reset).
REQ-005 SHALL have command ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_write (in, 1, 1=write/0=read), cmd_addr (in, ADDR_W), cmd_wdata (in, 32), cmd_wstrb (in, 4).
REQ-006 SHALL have response ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_write (out, 1), rsp_rdata (out, 32), rsp_resp (out, 2, AXI BRESP/RRESP).
REQ-007 SHALL have AXI-Lite master write ports m_awaddr (out, ADDR_W), m_awvalid (out), m_awready (in), m_wdata (out, 32), m_wstrb (out, 4), m_wvalid (out), m_wready (in), m_bresp (in, 2), m_bvalid (in), m_bready (out).
REQ-008 SHALL have AXI-Lite master read ports m_araddr (out, ADDR_W), m_arvalid (out), m_arready (in), m_rdata (in, 32), m_rresp (in, 2), m_rvalid (in), m_rready (out).
REQ-009 SHALL have counter ports wr_cnt (out, 32, completed writes), rd_cnt (out, 32, completed reads), err_cnt (out, 32, responses with resp != 2'b00).

Function
REQ-010 SHALL allow exactly one outstanding transaction; cmd_ready = 1 only in state IDLE.
REQ-011 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-012 SHALL, in IDLE on cmd_valid, register addr/wdata/wstrb/write and go to WR_REQ (write) or RD_REQ (read) on the next cycle.
REQ-013 SHALL, in WR_REQ, assert m_awvalid and m_wvalid together; each valid drops independently after its own handshake; go to WR_RESP once both have handshaken, including the case where both handshake in the same cycle.
REQ-014 SHALL hold m_awaddr/m_wdata/m_wstrb stable while the corresponding valid is high; valids never drop before ready.
REQ-015 SHALL, in WR_RESP, assert m_bready; on m_bvalid capture m_bresp and go to RSP.
REQ-016 SHALL, in RD_REQ, assert m_arvalid until m_arready, then go to RD_RESP.
REQ-017 SHALL, in RD_RESP, assert m_rready; on m_rvalid capture m_rdata/m_rresp and go to RSP.
REQ-018 SHALL, in RSP, assert rsp_valid with registered outputs held stable; on rsp_ready go to IDLE; rsp_rdata = 0 for writes.
REQ-019 SHALL give a minimum command-accept-to-rsp_valid latency of 3 cycles when the slave responds with zero wait.
REQ-020 SHALL increment wr_cnt/rd_cnt by 1 at the capture of B/R respectively, and err_cnt additionally when resp != 0; counters wrap from 0xFFFF_FFFF to 0.
REQ-021 SHALL drive no m_*valid and no m_*ready outside their owning states.

Reset
REQ-022 SHALL, on rst, go to IDLE and clear all valids, m_bready, m_rready, rsp_* outputs, and all three counters to 0.
REQ-023 SHALL abandon any in-flight transaction on rst mid-operation without issuing a response; the system resets the slave concurrently.

Structure
REQ-024 SHALL place the FSM state enum and the AXI response codes (OKAY=0, SLVERR=2, DECERR=3) in shared package axil_pkg.
REQ-025 SHALL be a single module with no sub-modules.

Verification
REQ-026 Write addr 0x0000_0504, data 0x10, strb 0xF, zero-wait slave -> one AW+W, rsp_write=1, rsp_resp=0, wr_cnt=1.
REQ-027 Read addr 0x0000_0508, slave returns 0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_resp=0, rd_cnt=1.
REQ-028 Write with awready delayed 5 cycles, wready immediate -> m_wvalid drops after 1 cycle, m_awvalid holds 5 cycles, single response.
REQ-029 Read with rresp=2'b10, rsp_ready held low 4 cycles -> rsp outputs stable 4 cycles, err_cnt=1, cmd_ready low throughout.
REQ-030 rst asserted in WR_RESP -> next cycle IDLE, all valids 0, counters 0, no rsp_valid.
